alu_cmd_issuer: RTL and testbench

Initiator for the team's combinational 4-bit ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's operand and opcode inputs from registers. It captures the ALU result, keeps a running accumulator, and returns the result over a second valid/ready handshake. It sits between a command source (test sequencer or microcontroller) and the ALU instance.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 23 ++
 rtl/alu_cmd_issuer.sv | 100 ++++++++++
 tb/tb_alu_cmd_issuer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command issuer: opcodes,
// issuer state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU driven by alu_cmd_issuer; results wrap mod 2^W.
module alu
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Drives a combinational ALU from registered operands and returns the result
// over valid/ready. Optional result flags under `ALU_ISSUER_FLAGS_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid is never withdrawn by this block before its transfer and
// the payload is held stable while valid is high.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_use_acc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  input  logic [W-1:0]     alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
`ifdef ALU_ISSUER_FLAGS_EN
  output logic             rsp_zero,
  output logic             rsp_neg,
`endif
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] ops_done,
  output logic [1:0]       state_dbg
);

  state_t       state, state_nx;
  logic [W-1:0] a_reg, b_reg;
  logic [1:0]   op_reg;
  logic         cmd_fire, rsp_fire;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      rsp_data <= '0;
      acc      <= '0;
      ops_done <= '0;
`ifdef ALU_ISSUER_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      // Operands only move on acceptance so the ALU inputs stay put otherwise.
      if (cmd_fire) begin
        a_reg  <= cmd_use_acc ? acc : cmd_a;
        b_reg  <= cmd_b;
        op_reg <= cmd_op;
      end
      if (state == EXEC) begin
        rsp_data <= alu_result;
        acc      <= alu_result;
`ifdef ALU_ISSUER_FLAGS_EN
        rsp_zero <= (alu_result == '0);
        rsp_neg  <= alu_result[W-1];
`endif
      end
      if (rsp_fire) ops_done <= ops_done + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer wired to the alu; expected responses are
// queued at command acceptance and checked at the response handshake.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_use_acc;
  logic [W-1:0]     cmd_a, cmd_b;
  logic [1:0]       cmd_op;
  logic [W-1:0]     alu_a, alu_b, alu_result, rsp_data, acc;
  logic [1:0]       alu_op, state_dbg;
  logic             rsp_valid, rsp_ready;
  logic [CNT_W-1:0] ops_done;
`ifdef ALU_ISSUER_FLAGS_EN
  logic             rsp_zero, rsp_neg;
`endif

  alu_cmd_issuer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ALU_ISSUER_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .acc(acc), .ops_done(ops_done), .state_dbg(state_dbg)
  );

  alu #(.W(W)) u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result));

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     model_acc = '0;
  logic [CNT_W-1:0] model_ops = '0;
  logic [W-1:0]     exp_a_q[$];

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, b, input logic [1:0] op);
    logic [W:0] t;
    case (op)
      2'b00:   t = {1'b0, a} + {1'b0, b};
      2'b01:   t = {1'b0, a} + {1'b0, ~b} + 1'b1;
      2'b10:   t = {1'b0, a & b};
      default: t = {1'b0, a | b};
    endcase
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a, b, input logic [1:0] op,
                      input logic ua, input bit push);
    int n;
    logic [W-1:0] ea;
    logic [W-1:0] r;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 20), 1);
    ea = ua ? model_acc : a;
    @(posedge clk);
    if (push) begin
      r = alu_model(ea, b, op);
      exp_q.push_back(r);
      model_acc = r;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_state", state_dbg, EXEC);
    chk("exec_no_rsp", rsp_valid, 0);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_op", alu_op, op);
  endtask

  task automatic wait_rsp();
    @(negedge clk);
    chk("rsp_latency", rsp_valid, 1);
  endtask

  task automatic recv(input int hold);
    logic [W-1:0] e;
    chk("exp_q_nonempty", (exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, e);
      @(negedge clk);
    end
    chk("rsp_data", rsp_data, e);
    chk("acc", acc, model_acc);
`ifdef ALU_ISSUER_FLAGS_EN
    chk("rsp_zero", rsp_zero, (e == '0));
    chk("rsp_neg", rsp_neg, e[W-1]);
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    model_ops = model_ops + 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ops_done", ops_done, model_ops);
    chk("idle_after_rsp", state_dbg, IDLE);
  endtask

  task automatic run_op(input logic [W-1:0] a, b, input logic [1:0] op, input logic ua);
    send(a, b, op, ua, 1'b1);
    wait_rsp();
    recv(0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Basic opcodes, including subtract wrap (3-5 = 14).
    run_op(4'd5, 4'd3, OP_ADD, 1'b0);
    run_op(4'd3, 4'd5, OP_SUB, 1'b0);
    run_op(4'd12, 4'd10, OP_AND, 1'b0);
    run_op(4'd12, 4'd3, OP_OR, 1'b0);

    // Accumulator chain: 0+7 then acc+9 wraps to 0; cmd_a must be ignored.
    run_op(4'd0, 4'd7, OP_ADD, 1'b0);
    run_op(4'd15, 4'd9, OP_ADD, 1'b1);
    chk("chain_acc_zero", acc, 0);

    // Backpressure with a competing command held on cmd_valid.
    send(4'd1, 4'd2, OP_ADD, 1'b0, 1'b1);
    wait_rsp();
    cmd_a = 4'd6; cmd_b = 4'd6; cmd_op = OP_ADD; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 4'd3);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_state", state_dbg, RESP);
      @(negedge clk);
    end
    recv(0);
    chk("bp_cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    exp_q.push_back(alu_model(4'd6, 4'd6, OP_ADD));
    model_acc = alu_model(4'd6, 4'd6, OP_ADD);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_new_accept", state_dbg, EXEC);
    wait_rsp();
    recv(2);

    // Reset during EXEC discards the operation.
    send(4'd9, 4'd9, OP_ADD, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_acc = '0;
    model_ops = '0;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_acc", acc, 0);
    chk("abort_ops_done", ops_done, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end

    // Counter wrap with CNT_W=2: 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      wait_rsp();
      recv(int'($urandom_range(0, 2)));
    end
    chk("wrap_ops_done", ops_done, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
